nonce_result_scanner: RTL and testbench
=======================================

Name: nonce_result_scanner

Overview:
Reader-side counterpart of the bitcoin hash co-processor's result writer. After the hasher reports done, this block reads the NUM_NONCES H0 words from output_addr over the same single-port word memory interface. It selects the nonce with the smallest H0, counts the nonces whose H0 is at or below a difficulty target, and writes a 3-word summary back to memory for the host.

Parameters:
NUM_NONCES, 16, number of consecutive H0 words to scan; legal range 1..65535
CNT_W, 16, width of hit_count

Ports:
clk  in  1  system clock; also drives mem_clk
reset  in  1  synchronous, active-high reset
start  in  1  scan request; sampled only in IDLE
output_addr  in  16  base address of the H0 array; nonce n is at output_addr+n
summary_addr  in  16  base address of the 3-word summary
target  in  32  unsigned difficulty target; an H0 is a hit when H0 <= target
done  out  1  one-cycle pulse when the summary has been written
busy  out  1  high in every state except IDLE
found  out  1  hit_count != 0; valid from done until the next start
best_nonce  out  32  index of the minimum H0, zero-extended
best_h0  out  32  minimum H0 value
hit_count  out  CNT_W  number of hits
mem_clk  out  1  equals clk
mem_we  out  1  1 = write, 0 = read
mem_addr  out  16  word address
mem_write_data  out  32  write data
mem_read_data  in  32  read data, registered by memory on mem_clk; valid the cycle after the address is driven

Behaviour:
- Reset values: done=0, busy=0, found=0, best_nonce=0, best_h0=32'hFFFFFFFF, hit_count=0, mem_we=0, mem_addr=0, mem_write_data=0; state=IDLE; idx=0.
- States: IDLE, RD, CMP, WR_H0, WR_NONCE, WR_CNT, DONE.
- IDLE with start=1:
  - latch output_addr, summary_addr and target;
  - set idx=0, best_h0=FFFFFFFF, best_nonce=0, hit_count=0, found=0;
  - go to RD.
- IDLE with start=0: stay. mem_we=0 throughout IDLE.
- RD: mem_we=0, mem_addr=base+idx (16-bit modulo add; wraps past FFFF). Go to CMP.
- CMP: v=mem_read_data.
  - If v < best_h0 (strict, unsigned): best_h0=v, best_nonce=idx. On a tie the lower nonce is kept.
  - If v <= target: hit_count+1, saturating at all-ones.
  - If idx==NUM_NONCES-1, go to WR_H0; otherwise idx+1 and go to RD.
- WR_H0: mem_we=1, mem_addr=sbase, data=best_h0.
- WR_NONCE: mem_we=1, mem_addr=sbase+1, data=best_nonce.
- WR_CNT: mem_we=1, mem_addr=sbase+2, data=zero-extended hit_count.
- Summary addresses wrap modulo 2^16.
- DONE: mem_we=0, done=1 for exactly one cycle, found=(hit_count!=0). Go to IDLE.
- Latency: done is high in cycle S+2*NUM_NONCES+4, where S is the cycle in which start is sampled. NUM_NONCES=16 gives S+36. Exactly NUM_NONCES reads and 3 writes are issued per scan.
- start while busy is ignored, with no restart or queueing. start held high re-triggers a scan in the cycle after DONE (IDLE samples it).
- Inputs changing mid-scan have no effect, because they are latched at start.
- Outputs best_h0, best_nonce, hit_count and found hold their values from DONE until the next accepted start.
- target=FFFFFFFF: every word is a hit. target=0: only H0==0 hits.
- Reset asserted mid-scan: at the next edge the block returns to IDLE with reset values and mem_we=0. Any summary words already written stay in memory; no further writes occur.
- mem_we is never high outside the WR_* states.

Test Plan:
- N=16, output_addr=2000, H0[n]=32'h80000000-n*16, target=32'h7FFFFF00 -> best_nonce=15, best_h0=7FFFFF10, hit_count=0, found=0; mem[sbase..+2]={7FFFFF10,0000000F,0}; done at S+36.
- Same data with target=7FFFFFB0 -> hit_count=11 (n=5..15), found=1.
- Ties: H0[3]=H0[9]=00000005, all others FFFFFFF0, target=5 -> best_nonce=3, hit_count=2.
- Wrap: output_addr=FFFA with N=16 -> read addresses FFFA..FFFF then 0000..0009; summary_addr=FFFF -> writes to FFFF, 0000, 0001.
- start pulsed again at S+10, and start held high for 40 cycles -> the first scan is unaffected; exactly one extra scan begins at S+37; reads never exceed 16 per scan.
- reset asserted at S+20 for 1 cycle -> next cycle busy=0 and mem_we=0; no summary write; best_h0=FFFFFFFF; a new start then produces correct results.

Source files
------------

// File: rtl/nonce_result_scanner_if.sv
// Word-memory bus between the nonce scanner (master) and a single-port RAM.
// Ports: mem_we, mem_addr, mem_write_data from master; mem_read_data from slave.
interface nonce_result_scanner_if;
    logic        mem_we;
    logic [15:0] mem_addr;
    logic [31:0] mem_write_data;
    logic [31:0] mem_read_data;

    modport master (
        output mem_we,
        output mem_addr,
        output mem_write_data,
        input  mem_read_data
    );

    modport slave (
        input  mem_we,
        input  mem_addr,
        input  mem_write_data,
        output mem_read_data
    );
endinterface

// File: rtl/nonce_result_scanner.sv
// Scans NUM_NONCES H0 words, finds the minimum and counts hits <= target,
// then writes {best_h0, best_nonce, hit_count} to summary_addr.
// Ports: clk_i/reset_i, start_i, address/target inputs, done/busy/found and
// result outputs, mem_clk_o, and the master side of the memory bus.
module nonce_result_scanner #(
    parameter int NUM_NONCES = 16,
    parameter int CNT_W      = 16
) (
    input  logic             clk_i,
    input  logic             reset_i,
    input  logic             start_i,
    input  logic [15:0]      output_addr_i,
    input  logic [15:0]      summary_addr_i,
    input  logic [31:0]      target_i,
    output logic             done_o,
    output logic             busy_o,
    output logic             found_o,
    output logic [31:0]      best_nonce_o,
    output logic [31:0]      best_h0_o,
    output logic [CNT_W-1:0] hit_count_o,
    output logic             mem_clk_o,
    nonce_result_scanner_if.master mem
);

    typedef enum logic [2:0] {
        IDLE, RD, CMP, WR_H0, WR_NONCE, WR_CNT, DONE
    } state_t;

    state_t            state_q;
    logic [15:0]       base_q;
    logic [15:0]       sbase_q;
    logic [31:0]       target_q;
    logic [15:0]       idx_q;
    logic              done_q;
    logic              found_q;
    logic [31:0]       best_h0_q;
    logic [15:0]       best_nonce_q;
    logic [CNT_W-1:0]  hit_q;
    logic              we_q;
    logic [15:0]       addr_q;
    logic [31:0]       wdata_q;

    logic [31:0]       best_h0_d;
    logic [15:0]       best_nonce_d;
    logic [CNT_W-1:0]  hit_d;
    logic [15:0]       idx_d;
    logic              last;

    // Result of folding the word returned in CMP into the running stats.
    always_comb begin
        best_h0_d    = best_h0_q;
        best_nonce_d = best_nonce_q;
        hit_d        = hit_q;
        idx_d        = idx_q + 16'd1;
        last         = (idx_q == 16'(NUM_NONCES - 1));
        // Strict compare keeps the lower nonce on a tie.
        if (mem.mem_read_data < best_h0_q) begin
            best_h0_d    = mem.mem_read_data;
            best_nonce_d = idx_q;
        end
        if (mem.mem_read_data <= target_q && hit_q != '1) begin
            hit_d = hit_q + CNT_W'(1);
        end
    end

    // Bus outputs are registered on the transition into the state that
    // owns them, so the RAM sees the address during RD and data in CMP.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q      <= IDLE;
            base_q       <= '0;
            sbase_q      <= '0;
            target_q     <= '0;
            idx_q        <= '0;
            done_q       <= 1'b0;
            found_q      <= 1'b0;
            best_h0_q    <= '1;
            best_nonce_q <= '0;
            hit_q        <= '0;
            we_q         <= 1'b0;
            addr_q       <= '0;
            wdata_q      <= '0;
        end else begin
            done_q <= 1'b0;
            we_q   <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (start_i) begin
                        base_q       <= output_addr_i;
                        sbase_q      <= summary_addr_i;
                        target_q     <= target_i;
                        idx_q        <= '0;
                        best_h0_q    <= '1;
                        best_nonce_q <= '0;
                        hit_q        <= '0;
                        found_q      <= 1'b0;
                        addr_q       <= output_addr_i;
                        state_q      <= RD;
                    end
                end
                RD: state_q <= CMP;
                CMP: begin
                    best_h0_q    <= best_h0_d;
                    best_nonce_q <= best_nonce_d;
                    hit_q        <= hit_d;
                    if (last) begin
                        we_q    <= 1'b1;
                        addr_q  <= sbase_q;
                        wdata_q <= best_h0_d;
                        state_q <= WR_H0;
                    end else begin
                        idx_q   <= idx_d;
                        addr_q  <= base_q + idx_d;
                        state_q <= RD;
                    end
                end
                WR_H0: begin
                    we_q    <= 1'b1;
                    addr_q  <= sbase_q + 16'd1;
                    wdata_q <= 32'(best_nonce_q);
                    state_q <= WR_NONCE;
                end
                WR_NONCE: begin
                    we_q    <= 1'b1;
                    addr_q  <= sbase_q + 16'd2;
                    wdata_q <= 32'(hit_q);
                    state_q <= WR_CNT;
                end
                WR_CNT: begin
                    done_q  <= 1'b1;
                    found_q <= (hit_q != '0);
                    state_q <= DONE;
                end
                DONE: state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end

    assign done_o             = done_q;
    assign busy_o             = (state_q != IDLE);
    assign found_o            = found_q;
    assign best_nonce_o       = 32'(best_nonce_q);
    assign best_h0_o          = best_h0_q;
    assign hit_count_o        = hit_q;
    assign mem_clk_o          = clk_i;
    assign mem.mem_we         = we_q;
    assign mem.mem_addr       = addr_q;
    assign mem.mem_write_data = wdata_q;

endmodule

// File: tb/tb_nonce_result_scanner.sv
// Bench for nonce_result_scanner: RAM model, cycle-accurate reference model
// and directed scans with literal expectations.
module tb_nonce_result_scanner;
    localparam int N  = 16;
    localparam int CW = 16;

    logic          clk = 1'b0;
    logic          reset;
    logic          start;
    logic [15:0]   output_addr;
    logic [15:0]   summary_addr;
    logic [31:0]   target;
    logic          done_o;
    logic          busy_o;
    logic          found_o;
    logic [31:0]   best_nonce_o;
    logic [31:0]   best_h0_o;
    logic [CW-1:0] hit_count_o;
    logic          mem_clk_o;

    nonce_result_scanner_if bus ();

    nonce_result_scanner #(.NUM_NONCES(N), .CNT_W(CW)) dut (
        .clk_i          (clk),
        .reset_i        (reset),
        .start_i        (start),
        .output_addr_i  (output_addr),
        .summary_addr_i (summary_addr),
        .target_i       (target),
        .done_o         (done_o),
        .busy_o         (busy_o),
        .found_o        (found_o),
        .best_nonce_o   (best_nonce_o),
        .best_h0_o      (best_h0_o),
        .hit_count_o    (hit_count_o),
        .mem_clk_o      (mem_clk_o),
        .mem            (bus)
    );

    always #5 clk = ~clk;

    // RAM with a host preload port; DUT writes take priority.
    logic [31:0] mem [0:65535];
    logic        h_we = 1'b0;
    logic [15:0] h_addr = '0;
    logic [31:0] h_data = '0;
    int          wcnt = 0;
    int          cyc = 0;

    always @(posedge mem_clk_o) begin
        if (bus.mem_we) begin
            mem[bus.mem_addr] <= bus.mem_write_data;
            wcnt <= wcnt + 1;
        end else if (h_we) begin
            mem[h_addr] <= h_data;
        end
        bus.mem_read_data <= mem[bus.mem_addr];
    end

    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)",
                     nm, act, exp, cyc);
        end
    endtask

    // Reference model: results computed from the RAM contents at start,
    // output timing derived from the cycle offset since start.
    bit          m_on = 1'b0;
    int          m_s = 0;
    int          m_scans = 0;
    logic [15:0] m_base, m_sbase;
    logic [31:0] m_bh = '1;
    logic [31:0] m_bn = '0;
    logic [31:0] m_hits = '0;
    logic        m_found = 1'b0;

    task automatic model_scan(input logic [15:0] b, input logic [31:0] t);
        logic [31:0] v;
        m_bh   = '1;
        m_bn   = '0;
        m_hits = '0;
        for (int n = 0; n < N; n++) begin
            v = mem[b + 16'(n)];
            if (v < m_bh) begin
                m_bh = v;
                m_bn = 32'(n);
            end
            if (v <= t) m_hits = m_hits + 1;
        end
        m_found = (m_hits != 0);
    endtask

    always @(negedge clk) begin
        int rel;
        int k;
        logic [31:0] wexp;
        rel = cyc - m_s;
        if (m_on && rel > 2 * N + 4) m_on = 1'b0;
        if (!m_on) begin
            chk("idle_busy", 32'(busy_o), 0);
            chk("idle_we", 32'(bus.mem_we), 0);
            chk("idle_done", 32'(done_o), 0);
            chk("hold_h0", best_h0_o, m_bh);
            chk("hold_nonce", best_nonce_o, m_bn);
            chk("hold_hits", 32'(hit_count_o), m_hits);
            chk("hold_found", 32'(found_o), 32'(m_found));
        end else if (rel <= 2 * N) begin
            chk("scan_busy", 32'(busy_o), 1);
            chk("scan_we", 32'(bus.mem_we), 0);
            chk("scan_done", 32'(done_o), 0);
            if (rel % 2 == 1)
                chk("rd_addr", 32'(bus.mem_addr),
                    32'(16'(m_base + 16'((rel - 1) / 2))));
        end else if (rel <= 2 * N + 3) begin
            k = rel - 2 * N - 1;
            wexp = (k == 0) ? m_bh : (k == 1) ? m_bn : m_hits;
            chk("wr_busy", 32'(busy_o), 1);
            chk("wr_we", 32'(bus.mem_we), 1);
            chk("wr_done", 32'(done_o), 0);
            chk("wr_addr", 32'(bus.mem_addr),
                32'(16'(m_sbase + 16'(k))));
            chk("wr_data", bus.mem_write_data, wexp);
        end else begin
            chk("done_pulse", 32'(done_o), 1);
            chk("done_busy", 32'(busy_o), 1);
            chk("done_we", 32'(bus.mem_we), 0);
            chk("done_h0", best_h0_o, m_bh);
            chk("done_nonce", best_nonce_o, m_bn);
            chk("done_hits", 32'(hit_count_o), m_hits);
            chk("done_found", 32'(found_o), 32'(m_found));
        end
        if (reset) begin
            m_on    = 1'b0;
            m_bh    = '1;
            m_bn    = '0;
            m_hits  = '0;
            m_found = 1'b0;
        end else if (!m_on && start) begin
            m_base  = output_addr;
            m_sbase = summary_addr;
            model_scan(output_addr, target);
            m_on = 1'b1;
            m_s  = cyc;
            m_scans++;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic hw(input logic [15:0] a, input logic [31:0] d);
        h_we   = 1'b1;
        h_addr = a;
        h_data = d;
        tick();
        h_we = 1'b0;
    endtask

    task automatic run(output int lat);
        int s;
        s = cyc;
        start = 1'b1;
        tick();
        start = 1'b0;
        lat = -1;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (done_o) begin
                lat = cyc - s;
                break;
            end
        end
        if (lat < 0) chk("done_timeout", 0, 1);
    endtask

    initial begin
        int lat;
        int s1;
        int sc0;
        int w0;
        reset        = 1'b1;
        start        = 1'b0;
        output_addr  = '0;
        summary_addr = '0;
        target       = '0;
        repeat (3) tick();
        chk("rst_busy", 32'(busy_o), 0);
        chk("rst_h0", best_h0_o, 32'hFFFFFFFF);
        chk("rst_hits", 32'(hit_count_o), 0);
        reset = 1'b0;
        tick();

        // Descending H0 words; no hit at the low target.
        for (int n = 0; n < N; n++)
            hw(16'(2000 + n), 32'h80000000 - 32'(n * 16));
        output_addr  = 16'd2000;
        summary_addr = 16'd3000;
        target       = 32'h7FFFFF00;
        run(lat);
        chk("t1_latency", 32'(lat), 36);
        chk("t1_nonce", best_nonce_o, 15);
        chk("t1_h0", best_h0_o, 32'h7FFFFF10);
        chk("t1_hits", 32'(hit_count_o), 0);
        chk("t1_found", 32'(found_o), 0);
        chk("t1_mem0", mem[3000], 32'h7FFFFF10);
        chk("t1_mem1", mem[3001], 32'h0000000F);
        chk("t1_mem2", mem[3002], 0);
        tick();

        target = 32'h7FFFFFB0;
        run(lat);
        chk("t2_hits", 32'(hit_count_o), 11);
        chk("t2_found", 32'(found_o), 1);
        chk("t2_mem2", mem[3002], 11);
        tick();

        // Tie between nonces 3 and 9.
        for (int n = 0; n < N; n++)
            hw(16'(100 + n), (n == 3 || n == 9) ? 32'd5 : 32'hFFFFFFF0);
        output_addr  = 16'd100;
        summary_addr = 16'd200;
        target       = 32'd5;
        run(lat);
        chk("t3_nonce", best_nonce_o, 3);
        chk("t3_h0", best_h0_o, 5);
        chk("t3_hits", 32'(hit_count_o), 2);
        tick();

        // Address wrap on both the array and the summary.
        for (int n = 0; n < N; n++)
            hw(16'hFFFA + 16'(n), 32'h10 + 32'((n * 7 + 3) % 16));
        output_addr  = 16'hFFFA;
        summary_addr = 16'hFFFF;
        target       = 32'h13;
        run(lat);
        chk("t4_memFFFF", mem[16'hFFFF], 32'h10);
        chk("t4_mem0000", mem[16'h0000], 11);
        chk("t4_mem0001", mem[16'h0001], 4);
        tick();

        // Extra start pulses while busy, then start held high.
        output_addr  = 16'd2000;
        summary_addr = 16'd3000;
        target       = 32'h7FFFFFB0;
        sc0 = m_scans;
        s1  = cyc;
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (8) tick();
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (9) tick();
        start = 1'b1;
        repeat (40) tick();
        start = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (!busy_o) break;
        end
        chk("t5_scans", 32'(m_scans - sc0), 2);
        chk("t5_restart", 32'(m_s - s1), 37);
        chk("t5_hits", 32'(hit_count_o), 11);
        tick();

        // Reset in the middle of a scan.
        w0 = wcnt;
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (19) tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        @(negedge clk);
        chk("t6_busy", 32'(busy_o), 0);
        chk("t6_we", 32'(bus.mem_we), 0);
        chk("t6_h0", best_h0_o, 32'hFFFFFFFF);
        repeat (5) tick();
        chk("t6_nowrite", 32'(wcnt - w0), 0);
        run(lat);
        chk("t6_lat", 32'(lat), 36);
        chk("t6_hits", 32'(hit_count_o), 11);
        chk("t6_h0_after", best_h0_o, 32'h7FFFFF10);
        repeat (3) tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
